tile_map_writer: RTL and testbench

//  Write side of the ant-farm tile display. Owns the full 14x10 grid of 3-bit RGB tiles and

---
 rtl/tile_map_pkg.sv | 24 ++
 rtl/tile_quadrant_slicer.sv | 19 +
 rtl/tile_map_writer.sv | 109 ++++++++++
 tb/tb_tile_map_writer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tile_map_pkg.sv
// Shared constants, FSM state type, write request struct and grid index helper for the tile map writer.
package tile_map_pkg;
  localparam int GRID_COLS = 14;
  localparam int GRID_ROWS = 10;
  localparam int Q_COLS    = 7;
  localparam int Q_ROWS    = 5;
  localparam int BPP       = 3;
  localparam int N_TILES   = GRID_COLS * GRID_ROWS;
  localparam int Q_TILES   = Q_COLS * Q_ROWS;
  localparam int IDX_W     = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TILES - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  typedef struct packed {
    logic [3:0]     row;
    logic [3:0]     col;
    logic [BPP-1:0] rgb;
  } wr_req_t;

  function automatic logic [IDX_W-1:0] tile_index(input logic [3:0] row, input logic [3:0] col);
    return IDX_W'(row) * IDX_W'(GRID_COLS) + IDX_W'(col);
  endfunction
endpackage

// File: rtl/tile_quadrant_slicer.sv
// Picks the 35 tiles of one quadrant out of the full 14x10 grid; purely combinational.
module tile_quadrant_slicer
  import tile_map_pkg::*;
(
  input  logic [N_TILES-1:0][BPP-1:0] grid,
  input  logic [1:0]                  quadrant,
  output logic [Q_TILES-1:0][BPP-1:0] tiles
);
  logic [3:0] row_off, col_off;

  assign row_off = quadrant[1] ? 4'(Q_ROWS) : 4'd0;
  assign col_off = quadrant[0] ? 4'(Q_COLS) : 4'd0;

  for (genvar r = 0; r < Q_ROWS; r++) begin : g_row
    for (genvar c = 0; c < Q_COLS; c++) begin : g_col
      assign tiles[r*Q_COLS+c] = grid[tile_index(4'(r) + row_off, 4'(c) + col_off)];
    end
  end
endmodule

// File: rtl/tile_map_writer.sv
// Tile grid write port with clear sweep and quadrant image output.
// TILE_WR_DOUBLE_BUF_EN: display from an active copy committed on vsync fall; otherwise straight from shadow.
module tile_map_writer
  import tile_map_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_btn,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [3:0]             wr_col,
  input  logic [3:0]             wr_row,
  input  logic [BPP-1:0]         wr_rgb,
  input  logic                   clr_req,
  input  logic [BPP-1:0]         clr_rgb,
  output logic                   clr_done,
  input  logic                   vsync,
  input  logic [1:0]             quadrant,
  output logic [Q_TILES*BPP-1:0] pixel_memory,
  output logic                   wr_err
);
  logic [N_TILES-1:0][BPP-1:0] shadow;
  logic [N_TILES-1:0][BPP-1:0] disp_src;
  logic [Q_TILES-1:0][BPP-1:0] q_tiles;
  state_t                      state;
  logic [IDX_W-1:0]            clr_idx;
  logic                        commit_pend;
  wr_req_t                     req;
  logic                        wr_fire, in_range;

  assign req      = '{row: wr_row, col: wr_col, rgb: wr_rgb};
  assign wr_ready = (state == IDLE) && !commit_pend;
  assign wr_fire  = wr_valid && wr_ready;
  assign in_range = (req.row < 4'(GRID_ROWS)) && (req.col < 4'(GRID_COLS));

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state    <= IDLE;
      clr_idx  <= '0;
      clr_done <= 1'b0;
      wr_err   <= 1'b0;
      shadow   <= '0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_fire) begin
            if (in_range) shadow[tile_index(req.row, req.col)] <= req.rgb;
            else          wr_err <= 1'b1;
          end
          if (clr_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
          end
        end
        CLEAR: begin
          shadow[clr_idx] <= clr_rgb;
          if (clr_idx == LAST_IDX) begin
            state    <= IDLE;
            clr_done <= 1'b1;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TILE_WR_DOUBLE_BUF_EN
  logic                        vs_d;
  logic [N_TILES-1:0][BPP-1:0] active;

  // A fall seen during CLEAR stays pending, so a half-swept grid never reaches active.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      vs_d        <= 1'b1;
      commit_pend <= 1'b0;
      active      <= '0;
    end else begin
      vs_d <= vsync;
      if (state == IDLE && commit_pend) begin
        active      <= shadow;
        commit_pend <= 1'b0;
      end else if (vs_d && !vsync) begin
        commit_pend <= 1'b1;
      end
    end
  end

  assign disp_src = active;
`else
  logic unused_vsync;

  assign unused_vsync = vsync;
  assign commit_pend  = 1'b0;
  assign disp_src     = shadow;
`endif

  tile_quadrant_slicer u_slicer (
    .grid     (disp_src),
    .quadrant (quadrant),
    .tiles    (q_tiles)
  );

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) pixel_memory <= '0;
    else          pixel_memory <= q_tiles;
  end
endmodule

// File: tb/tb_tile_map_writer.sv
// Randomized and directed bench for tile_map_writer against an array-based grid model.
module tb_tile_map_writer;
  logic         clk = 1'b0;
  logic         rst_btn = 1'b0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [3:0]   wr_col = '0, wr_row = '0;
  logic [2:0]   wr_rgb = '0;
  logic         clr_req = 1'b0;
  logic [2:0]   clr_rgb = '0;
  logic         clr_done;
  logic         vsync = 1'b1;
  logic [1:0]   quadrant = '0;
  logic [104:0] pixel_memory;
  logic         wr_err;

  int total = 0;
  int bad   = 0;

  tile_map_writer dut (
    .clk(clk), .rst_btn(rst_btn), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_col(wr_col), .wr_row(wr_row), .wr_rgb(wr_rgb), .clr_req(clr_req),
    .clr_rgb(clr_rgb), .clr_done(clr_done), .vsync(vsync), .quadrant(quadrant),
    .pixel_memory(pixel_memory), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  // Grid model: plain arrays, a count of tiles left to clear, a pending-commit flag.
  bit [2:0]   m_sh [140];
  bit [2:0]   m_ac [140];
  bit         m_pend, m_vs, m_done, m_err;
  int         m_left;
  bit [104:0] m_pix;

  function automatic bit model_ready();
    return (m_left == 0) && !m_pend;
  endfunction

  function automatic bit [104:0] view(input logic [1:0] q);
    bit [104:0] v;
    int src;
    v = '0;
    for (int i = 0; i < 35; i++) begin
      src = (i / 7 + 5 * int'(q[1])) * 14 + (i % 7) + 7 * int'(q[0]);
`ifdef TILE_WR_DOUBLE_BUF_EN
      v[3*i +: 3] = m_ac[src];
`else
      v[3*i +: 3] = m_sh[src];
`endif
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 140; i++) begin m_sh[i] = '0; m_ac[i] = '0; end
    m_pend = 0; m_vs = 1; m_done = 0; m_err = 0; m_left = 0; m_pix = '0;
  endtask

  task automatic model_step();
    bit rdy;
    int r, c;
    if (!rst_btn) begin model_reset(); return; end
    rdy    = model_ready();
    m_pix  = view(quadrant);
    m_done = (m_left == 1);
`ifdef TILE_WR_DOUBLE_BUF_EN
    if (m_left == 0 && m_pend) begin m_ac = m_sh; m_pend = 0; end
    else if (m_vs && !vsync) m_pend = 1;
    m_vs = vsync;
`endif
    if (m_left > 0) begin
      m_sh[140 - m_left] = clr_rgb;
      m_left--;
    end else begin
      if (wr_valid && rdy) begin
        r = int'(wr_row); c = int'(wr_col);
        if (r < 10 && c < 14) m_sh[r*14 + c] = wr_rgb;
        else m_err = 1;
      end
      if (clr_req) m_left = 140;
    end
  endtask

  task automatic chk(input string name, input logic [104:0] act, input logic [104:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic compare();
    chk("wr_ready", 105'(wr_ready), 105'(model_ready()));
    chk("clr_done", 105'(clr_done), 105'(m_done));
    chk("wr_err", 105'(wr_err), 105'(m_err));
    chk("pixel_memory", pixel_memory, m_pix);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic do_write(input int r, input int c, input int rgb);
    wr_valid = 1'b1; wr_row = 4'(r); wr_col = 4'(c); wr_rgb = 3'(rgb);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic commit();
    vsync = 1'b0; tick();
    vsync = 1'b1; tick(); tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowcnt, donecnt;
    bit [104:0] ones;
    ones = '1;
    model_reset();
    repeat (3) tick();
    rst_btn = 1'b1;

    // T1 reset state
    chk("t1_pix", pixel_memory, '0);
    chk("t1_ready", 105'(wr_ready), 105'(1));
    chk("t1_err", 105'(wr_err), 105'(0));

    // T2 write (2,3)=101, tile 17 of quadrant 0
    do_write(2, 3, 5);
    tick();
`ifdef TILE_WR_DOUBLE_BUF_EN
    chk("t2_before_commit", 105'(pixel_memory[53:51]), 105'(0));
    repeat (3) tick();
    chk("t2_still_hidden", 105'(pixel_memory[53:51]), 105'(0));
    commit();
`endif
    chk("t2_visible", 105'(pixel_memory[53:51]), 105'(3'b101));

    // T3 write (7,10)=010 is tile 17 of quadrant 3
    do_write(7, 10, 2);
    commit();
    quadrant = 2'd3; tick();
    chk("t3_q3", 105'(pixel_memory[53:51]), 105'(3'b010));
    quadrant = 2'd0; tick();
    chk("t3_q0", 105'(pixel_memory[53:51]), 105'(3'b101));

    // T4 clear to white with a vsync fall mid-sweep
    clr_rgb = 3'b111; clr_req = 1'b1;
    lowcnt = 0; donecnt = 0;
    for (int k = 0; k < 150; k++) begin
      vsync = (k == 50) ? 1'b0 : 1'b1;
      tick();
      clr_req = 1'b0;
      if (k < 140 && !wr_ready) lowcnt++;
      if (clr_done) donecnt++;
    end
    chk("t4_busy_cycles", 105'(lowcnt), 105'(140));
    chk("t4_done_pulses", 105'(donecnt), 105'(1));
    chk("t4_all_white_q0", pixel_memory, ones);
    quadrant = 2'd1; tick();
    chk("t4_all_white_q1", pixel_memory, ones);

    // T5 out-of-range write, then a write in the vsync-fall cycle
    do_write(12, 3, 0);
    chk("t5_err", 105'(wr_err), 105'(1));
    commit();
    chk("t5_grid_unchanged", pixel_memory, ones);
    quadrant = 2'd0;
    vsync = 1'b0;
    do_write(0, 0, 2);
    vsync = 1'b1;
    tick(); tick();
    chk("t5_fall_write", 105'(pixel_memory[2:0]), 105'(3'b010));

    // T6 reset in the middle of a clear
    clr_rgb = 3'b011; clr_req = 1'b1; tick(); clr_req = 1'b0;
    repeat (30) tick();
    rst_btn = 1'b0;
    #1;
    chk("t6_pix_async", pixel_memory, '0);
    chk("t6_err_async", 105'(wr_err), 105'(0));
    chk("t6_done_async", 105'(clr_done), 105'(0));
    tick(); tick();
    rst_btn = 1'b1;
    tick();
    chk("t6_ready", 105'(wr_ready), 105'(1));
    do_write(2, 3, 5);
    tick();
`ifdef TILE_WR_DOUBLE_BUF_EN
    chk("t6_rerun_hidden", 105'(pixel_memory[53:51]), 105'(0));
`else
    chk("t6_rerun_visible", 105'(pixel_memory[53:51]), 105'(3'b101));
`endif

    // random traffic, checked against the model every cycle
    for (int n = 0; n < 2000; n++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_row   = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      wr_col   = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(14, 15)) : 4'($urandom_range(0, 13));
      wr_rgb   = 3'($urandom_range(0, 7));
      clr_req  = ($urandom_range(0, 299) == 0);
      clr_rgb  = 3'($urandom_range(0, 7));
      vsync    = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 19) == 0) quadrant = 2'($urandom_range(0, 3));
      tick();
    end
    wr_valid = 1'b0; clr_req = 1'b0; vsync = 1'b1;
    repeat (150) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
